// File: rtl/mux_nto1_reg.sv
// Registered N-to-1 channel mux with valid/ready output; each sample carries its channel index.
// Optional auto-scan mode (SCAN state, scan pointer, dwell counter) built only with MUX_NTO1_SCAN_EN.
module mux_nto1_reg #(
  parameter int unsigned N     = 8,
  parameter int unsigned W     = 8,
  parameter int unsigned DWELL = 4,
  localparam int unsigned SW   = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            mode,
  input  logic [SW-1:0]   sel,
  input  logic [N*W-1:0]  d,
  output logic [W-1:0]    y,
  output logic [SW-1:0]   y_ch,
  output logic            y_valid,
  input  logic            y_ready
);

`ifdef MUX_NTO1_SCAN_EN
  typedef enum logic [1:0] {StIdle, StManual, StScan} state_e;
`else
  typedef enum logic [1:0] {StIdle, StManual} state_e;
`endif

  state_e        r_state;
  state_e        w_state_d;
  logic          w_load;
  logic [SW-1:0] w_ch;
  logic [W-1:0]  w_data;
  logic [W-1:0]  r_y;
  logic [SW-1:0] r_ch;
  logic          r_valid;

  assign w_load  = en && (!r_valid || y_ready);
  assign y       = r_y;
  assign y_ch    = r_ch;
  assign y_valid = r_valid;

  always_comb begin
    w_state_d = StIdle;
    if (en) w_state_d = StManual;
`ifdef MUX_NTO1_SCAN_EN
    if (en && mode) w_state_d = StScan;
`endif
  end

`ifdef MUX_NTO1_SCAN_EN
  logic [SW-1:0] r_ptr;
  logic [7:0]    r_cnt;
  logic [SW-1:0] w_ptr_eff;
  logic [7:0]    w_cnt_eff;

  // On entry from another state the scan always starts fresh at channel 0.
  assign w_ptr_eff = (r_state == StScan) ? r_ptr : '0;
  assign w_cnt_eff = (r_state == StScan) ? r_cnt : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr <= '0;
      r_cnt <= '0;
    end else if (w_state_d != StScan) begin
      r_ptr <= '0;
      r_cnt <= '0;
    end else if (w_load) begin
      if (w_cnt_eff + 8'd1 == 8'(DWELL)) begin
        r_cnt <= '0;
        r_ptr <= (w_ptr_eff == SW'(N - 1)) ? '0 : w_ptr_eff + SW'(1);
      end else begin
        r_cnt <= w_cnt_eff + 8'd1;
        r_ptr <= w_ptr_eff;
      end
    end
  end
`else
  logic w_unused_in;
  assign w_unused_in = mode ^ (^r_state);
`endif

  always_comb begin
    w_ch = sel;
`ifdef MUX_NTO1_SCAN_EN
    if (w_state_d == StScan) w_ch = w_ptr_eff;
`endif
    // Out-of-range indices (N not a power of two) fall through to zero data.
    w_data = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (w_ch == SW'(i)) w_data = d[i*W +: W];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_y     <= '0;
      r_ch    <= '0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_d;
      if (w_load) begin
        r_y     <= w_data;
        r_ch    <= w_ch;
        r_valid <= 1'b1;
      end else if (r_valid && y_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux_nto1_reg.sv
// Directed self-checking bench for mux_nto1_reg: an N=8 instance plus an N=5 instance
// for out-of-range select; scan scenarios run only when MUX_NTO1_SCAN_EN is defined.
module tb_mux_nto1_reg;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en, mode, y_ready;
  logic [2:0]  sel;
  logic [63:0] d;
  logic [7:0]  y;
  logic [2:0]  y_ch;
  logic        y_valid;

  logic        en5, ready5;
  logic [2:0]  sel5;
  logic [39:0] d5;
  logic [7:0]  y5;
  logic [2:0]  y_ch5;
  logic        y_valid5;

  int n_total = 0;
  int n_bad   = 0;

  mux_nto1_reg #(.N(8), .W(8), .DWELL(4)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel), .d(d),
    .y(y), .y_ch(y_ch), .y_valid(y_valid), .y_ready(y_ready)
  );

  mux_nto1_reg #(.N(5), .W(8), .DWELL(4)) dut5 (
    .clk(clk), .rst_n(rst_n), .en(en5), .mode(1'b0), .sel(sel5), .d(d5),
    .y(y5), .y_ch(y_ch5), .y_valid(y_valid5), .y_ready(ready5)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; mode = 1'b0; sel = 3'd3; y_ready = 1'b1;
    en5 = 1'b1; sel5 = 3'd2; ready5 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_total++;
      if ({y_valid, y_ch, y} !== 12'h000) begin
        n_bad++;
        $display("FAIL reset%0d got v=%b ch=%0d y=%h want v=0 ch=0 y=00", i, y_valid, y_ch, y);
      end
    end
    n_total++;
    if ({y_valid5, y_ch5, y5} !== 12'h000) begin
      n_bad++;
      $display("FAIL reset_n5 got v=%b ch=%0d y=%h want v=0 ch=0 y=00", y_valid5, y_ch5, y5);
    end
    rst_n = 1'b1;
    tick();
    n_total++;
    if ({y_valid, y_ch, y} !== {1'b1, 3'd3, 8'h13}) begin
      n_bad++;
      $display("FAIL reset_release got v=%b ch=%0d y=%h want v=1 ch=3 y=13", y_valid, y_ch, y);
    end
    n_total++;
    if ({y_valid5, y_ch5, y5} !== {1'b1, 3'd2, 8'h12}) begin
      n_bad++;
      $display("FAIL reset_release_n5 got v=%b ch=%0d y=%h want v=1 ch=2 y=12",
               y_valid5, y_ch5, y5);
    end
  endtask

  task automatic test_manual();
    logic [2:0] ech;
    logic [7:0] ey;
    en = 1'b1; mode = 1'b0; y_ready = 1'b1;
    for (int s = 0; s < 8; s++) begin
      ech = 3'(s);
      ey  = 8'h10 + 8'(s);
      sel = ech;
      tick();
      n_total++;
      if ({y_valid, y_ch, y} !== {1'b1, ech, ey}) begin
        n_bad++;
        $display("FAIL manual_sel%0d got v=%b ch=%0d y=%h want v=1 ch=%0d y=%h",
                 s, y_valid, y_ch, y, ech, ey);
      end
    end
  endtask

  task automatic test_backpressure();
    sel = 3'd2; y_ready = 1'b1;
    tick();
    y_ready = 1'b0;
    for (int s = 2; s <= 6; s++) begin
      sel = 3'(s);
      tick();
      n_total++;
      if ({y_valid, y_ch, y} !== {1'b1, 3'd2, 8'h12}) begin
        n_bad++;
        $display("FAIL stall%0d got v=%b ch=%0d y=%h want v=1 ch=2 y=12", s, y_valid, y_ch, y);
      end
    end
    // Consume of 12 and load of 16 share one edge.
    y_ready = 1'b1;
    tick();
    n_total++;
    if ({y_valid, y_ch, y} !== {1'b1, 3'd6, 8'h16}) begin
      n_bad++;
      $display("FAIL stall_release got v=%b ch=%0d y=%h want v=1 ch=6 y=16", y_valid, y_ch, y);
    end
    en = 1'b0;
    tick();
    n_total++;
    if ({y_valid, y_ch, y} !== {1'b0, 3'd6, 8'h16}) begin
      n_bad++;
      $display("FAIL idle_drop got v=%b ch=%0d y=%h want v=0 ch=6 y=16", y_valid, y_ch, y);
    end
  endtask

  task automatic test_disable_edge();
    logic [2:0] sv [3] = '{3'd4, 3'd5, 3'd7};
    logic [7:0] yv [3] = '{8'h14, 8'h00, 8'h00};
    en5 = 1'b1; ready5 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sel5 = sv[i];
      tick();
      n_total++;
      if ({y_valid5, y_ch5, y5} !== {1'b1, sv[i], yv[i]}) begin
        n_bad++;
        $display("FAIL n5_sel%0d got v=%b ch=%0d y=%h want v=1 ch=%0d y=%h",
                 sv[i], y_valid5, y_ch5, y5, sv[i], yv[i]);
      end
    end
    en5 = 1'b0; ready5 = 1'b0; sel5 = 3'd1;
    tick();
    n_total++;
    if ({y_valid5, y_ch5, y5} !== {1'b1, 3'd7, 8'h00}) begin
      n_bad++;
      $display("FAIL n5_frozen got v=%b ch=%0d y=%h want v=1 ch=7 y=00", y_valid5, y_ch5, y5);
    end
    ready5 = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_total++;
      if ({y_valid5, y_ch5, y5} !== {1'b0, 3'd7, 8'h00}) begin
        n_bad++;
        $display("FAIL n5_drop%0d got v=%b ch=%0d y=%h want v=0 ch=7 y=00",
                 i, y_valid5, y_ch5, y5);
      end
    end
  endtask

`ifdef MUX_NTO1_SCAN_EN
  task automatic test_scan();
    int k = 0;
    int stalls = 0;
    logic [2:0] ech;
    logic [2:0] last_ch = 3'd0;
    en = 1'b0; y_ready = 1'b1;
    tick();
    en = 1'b1; mode = 1'b1;
    while (k < 41) begin
      if (k == 10 && stalls < 3) begin
        y_ready = 1'b0;
        stalls++;
        tick();
        n_total++;
        if ({y_valid, y_ch} !== {1'b1, last_ch}) begin
          n_bad++;
          $display("FAIL scan_stall%0d got v=%b ch=%0d want v=1 ch=%0d",
                   stalls, y_valid, y_ch, last_ch);
        end
      end else begin
        y_ready = 1'b1;
        ech = 3'((k / 4) % 8);
        tick();
        n_total++;
        if ({y_valid, y_ch, y} !== {1'b1, ech, 8'h10 + 8'(ech)}) begin
          n_bad++;
          $display("FAIL scan_load%0d got v=%b ch=%0d y=%h want v=1 ch=%0d", k, y_valid, y_ch, y, ech);
        end
        last_ch = ech;
        k++;
      end
    end
  endtask

  task automatic test_mode_switch();
    logic [2:0] ech;
    en = 1'b0; y_ready = 1'b1;
    tick();
    en = 1'b1; mode = 1'b1;
    // 22 loads leave ptr=5, cnt=2.
    for (int i = 0; i < 22; i++) tick();
    n_total++;
    if (y_ch !== 3'd5) begin
      n_bad++;
      $display("FAIL switch_pre got ch=%0d want ch=5", y_ch);
    end
    mode = 1'b0; sel = 3'd3;
    tick();
    n_total++;
    if ({y_valid, y_ch, y} !== {1'b1, 3'd3, 8'h13}) begin
      n_bad++;
      $display("FAIL switch_manual got v=%b ch=%0d y=%h want v=1 ch=3 y=13", y_valid, y_ch, y);
    end
    mode = 1'b1;
    for (int i = 0; i < 5; i++) begin
      ech = (i < 4) ? 3'd0 : 3'd1;
      tick();
      n_total++;
      if ({y_valid, y_ch} !== {1'b1, ech}) begin
        n_bad++;
        $display("FAIL switch_rescan%0d got v=%b ch=%0d want v=1 ch=%0d", i, y_valid, y_ch, ech);
      end
    end
    mode = 1'b0;
  endtask
`endif

  task automatic test_reset_drop();
    en = 1'b1; mode = 1'b0; sel = 3'd1; y_ready = 1'b1;
    tick();
    y_ready = 1'b0; rst_n = 1'b0;
    tick();
    n_total++;
    if ({y_valid, y_ch, y} !== 12'h000) begin
      n_bad++;
      $display("FAIL reset_pending got v=%b ch=%0d y=%h want v=0 ch=0 y=00", y_valid, y_ch, y);
    end
    rst_n = 1'b1; y_ready = 1'b1;
    tick();
    n_total++;
    if ({y_valid, y_ch, y} !== {1'b1, 3'd1, 8'h11}) begin
      n_bad++;
      $display("FAIL reset_resume got v=%b ch=%0d y=%h want v=1 ch=1 y=11", y_valid, y_ch, y);
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) d[i*8 +: 8] = 8'h10 + 8'(i);
    for (int i = 0; i < 5; i++) d5[i*8 +: 8] = 8'h10 + 8'(i);
    test_reset();
    test_manual();
    test_backpressure();
    test_disable_edge();
`ifdef MUX_NTO1_SCAN_EN
    test_scan();
    test_mode_switch();
`endif
    test_reset_drop();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
